// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and the data-memory responder.
interface dmem_responder_if #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [3:0]            req_be;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states
// and byte-lane stores restricted to naturally aligned byte/half/word shapes.
module dmem_responder #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
);
  localparam int unsigned IDX_W    = DM_ADDRESS - 2;
  localparam int unsigned DEPTH    = 1 << IDX_W;
  localparam int unsigned NLANES   = 4;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned CNT_INIT = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_INIT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic [IDX_W-1:0]    r_idx;
  logic [NLANES-1:0]   r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_handshake;
  logic                w_access;
  logic                w_acc_we;
  logic [IDX_W-1:0]    w_acc_idx;
  logic [NLANES-1:0]   w_acc_be;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic                w_be_legal;
  logic                w_commit;

  // Only single bytes, aligned halves and the full word are storable.
  function automatic logic be_legal(input logic [NLANES-1:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  endfunction

  assign w_handshake = (r_state == IDLE) && bus.req_valid && r_req_ready;

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request fields instead of the captured copies.
  assign w_access = (w_handshake && (LATENCY == 0)) ||
                    ((r_state == WAIT) && (r_cnt == '0));

  // Select live request fields in IDLE, captured fields otherwise.
  always_comb begin
    w_acc_we    = r_we;
    w_acc_idx   = r_idx;
    w_acc_be    = r_be;
    w_acc_wdata = r_wdata;
    if (r_state == IDLE) begin
      w_acc_we    = bus.req_we;
      w_acc_idx   = bus.req_addr[DM_ADDRESS-1:2];
      w_acc_be    = bus.req_be;
      w_acc_wdata = bus.req_wdata;
    end
  end

  assign w_be_legal = be_legal(w_acc_be);
  assign w_commit   = w_access && w_acc_we && w_be_legal;

  // Memory array: not reset; enabled lanes written on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < NLANES; i++) begin
        if (w_acc_be[i]) begin
          r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake outputs and response payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          if (w_handshake) begin
            r_we        <= bus.req_we;
            r_idx       <= bus.req_addr[DM_ADDRESS-1:2];
            r_be        <= bus.req_be;
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          // No new acceptance on the completing edge: ready rises with IDLE.
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Response fields are captured together with the memory access.
      if (w_access) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_acc_we && !w_be_legal;
        r_rsp_rdata <= w_acc_we ? '0 : r_mem[w_acc_idx];
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for data/timing/reset,
// LATENCY=0 instance for single-cycle response and back-to-back throughput.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) b2 ();
  dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) b0 ();

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on the LATENCY=2 instance; lat = cycles after accept edge.
  task automatic req2(input logic we, input logic [8:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    b2.req_we    = we;
    b2.req_addr  = addr;
    b2.req_be    = be;
    b2.req_wdata = wd;
    b2.req_valid = 1'b1;
    n = 0;
    while (b2.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    lat = 0;
    while (b2.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 20) chk("rsp_timeout", 32'(lat), 32'd2);
    rd = b2.rsp_rdata;
    er = b2.rsp_err;
    b2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b2.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    int          acc_cnt;
    int          prev_acc;
    logic        acc;

    b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = '0; b2.req_be = '0;
    b2.req_wdata = '0;   b2.rsp_ready = 1'b0;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_be = '0;
    b0.req_wdata = '0;   b0.rsp_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_req_ready", 32'(b2.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", b2.rsp_rdata, 32'd0);
    chk("rst_rsp_err",   32'(b2.rsp_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(b2.req_ready), 32'd1);

    // Full-word store then load.
    req2(1'b1, 9'h010, 4'b1111, 32'hDEADBEEF, rd, er, lat);
    chk("st_lat", 32'(lat), 32'd2);
    chk("st_err", 32'(er), 32'd0);
    chk("st_rdata", rd, 32'd0);
    req2(1'b0, 9'h010, 4'b0000, 32'h0, rd, er, lat);
    chk("ld_lat", 32'(lat), 32'd2);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    chk("ld_err", 32'(er), 32'd0);

    // Single-lane store merges; load ignores addr[1:0] and be.
    req2(1'b1, 9'h011, 4'b0010, 32'h55555555, rd, er, lat);
    chk("b1_err", 32'(er), 32'd0);
    req2(1'b0, 9'h012, 4'b0101, 32'hFFFFFFFF, rd, er, lat);
    chk("b1_merge", rd, 32'hDEAD55EF);

    // Illegal lane pattern rejected without writing.
    req2(1'b1, 9'h020, 4'b1111, 32'h12345678, rd, er, lat);
    req2(1'b1, 9'h020, 4'b0101, 32'hFFFFFFFF, rd, er, lat);
    chk("ill_err", 32'(er), 32'd1);
    chk("ill_rdata", rd, 32'd0);
    req2(1'b0, 9'h020, 4'b1111, 32'h0, rd, er, lat);
    chk("ill_reload", rd, 32'h12345678);
    chk("ill_reload_err", 32'(er), 32'd0);

    // Response held under backpressure.
    b2.req_we = 1'b0; b2.req_addr = 9'h020; b2.req_valid = 1'b1;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    n = 0;
    while (b2.rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(b2.rsp_valid), 32'd1);
      chk("stall_rdata", b2.rsp_rdata, 32'h12345678);
      chk("stall_ready", 32'(b2.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    b2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b2.rsp_ready = 1'b0;
    chk("release_valid", 32'(b2.rsp_valid), 32'd0);
    chk("release_ready", 32'(b2.req_ready), 32'd1);

    // Reset during WAIT aborts the pending store.
    req2(1'b1, 9'h030, 4'b1111, 32'h00000000, rd, er, lat);
    b2.req_we = 1'b1; b2.req_addr = 9'h030; b2.req_be = 4'b1111;
    b2.req_wdata = 32'hCAFEF00D; b2.req_valid = 1'b1;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("wrst_req_ready", 32'(b2.req_ready), 32'd0);
    chk("wrst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
    chk("wrst_rsp_rdata", b2.rsp_rdata, 32'd0);
    chk("wrst_rsp_err",   32'(b2.rsp_err), 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("wrst_ready_back", 32'(b2.req_ready), 32'd1);
    req2(1'b0, 9'h030, 4'b1111, 32'h0, rd, er, lat);
    chk("wrst_reload", rd, 32'h00000000);

    // Reset during RESP drops the response; committed store survives.
    req2(1'b1, 9'h040, 4'b1111, 32'hAAAA5555, rd, er, lat);
    b2.req_we = 1'b0; b2.req_addr = 9'h040; b2.req_valid = 1'b1;
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    n = 0;
    while (b2.rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("rrst_pre_rdata", b2.rsp_rdata, 32'hAAAA5555);
    #2 rst_n = 1'b0;
    #1;
    chk("rrst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
    chk("rrst_rsp_rdata", b2.rsp_rdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    req2(1'b0, 9'h040, 4'b1111, 32'h0, rd, er, lat);
    chk("rrst_reload", rd, 32'hAAAA5555);

    // Zero wait states: response right after accept edge.
    b0.req_we = 1'b1; b0.req_addr = 9'h004; b0.req_be = 4'b1111;
    b0.req_wdata = 32'h11111111; b0.req_valid = 1'b1;
    chk("l0_ready", 32'(b0.req_ready), 32'd1);
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    chk("l0_st_valid", 32'(b0.rsp_valid), 32'd1);
    chk("l0_st_err", 32'(b0.rsp_err), 32'd0);
    b0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("l0_st_done", 32'(b0.rsp_valid), 32'd0);

    // Held request with rsp_ready tied high: one accept every two cycles.
    b0.req_we = 1'b0; b0.req_valid = 1'b1;
    acc_cnt = 0;
    prev_acc = -1;
    for (int c = 0; c < 8; c++) begin
      acc = b0.req_valid & b0.req_ready;
      if (acc) begin
        if (prev_acc >= 0) chk("l0_spacing", 32'(c - prev_acc), 32'd2);
        prev_acc = c;
        acc_cnt++;
      end
      @(posedge clk); #1;
      if (acc) begin
        chk("l0_ld_valid", 32'(b0.rsp_valid), 32'd1);
        chk("l0_ld_rdata", b0.rsp_rdata, 32'h11111111);
      end
    end
    chk("l0_accepts", 32'(acc_cnt), 32'd4);
    b0.req_valid = 1'b0;
    b0.rsp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, byte-address width; word depth 2**(DM_ADDRESS-2).
REQ-002 SHALL have parameter DATA_W, default 32, data width; fixed at 32, 4 byte lanes.
REQ-003 SHALL have parameter LATENCY, default 2, wait states between acceptance and response, legal 0..7.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1, initiator request present.
REQ-007 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-008 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, DM_ADDRESS, byte address; word index = req_addr[DM_ADDRESS-1:2].
REQ-010 SHALL have port req_be, input, 4, byte-lane write enables; bit i enables wdata[8i+7:8i].
REQ-011 SHALL have port req_wdata, input, DATA_W, store data, lane-replicated by initiator.
REQ-012 SHALL have port rsp_valid, output, 1, response present.
REQ-013 SHALL have port rsp_ready, input, 1, initiator accepts response.
REQ-014 SHALL have port rsp_rdata, output, DATA_W, full addressed word for loads; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1, request rejected as illegal.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 IDLE: req_ready=1, rsp_valid=0; handshake = req_valid & req_ready at rising edge; captures we, addr, be, wdata.
REQ-018 On handshake: LATENCY=0 -> RESP directly; else -> WAIT with counter loaded LATENCY-1.
REQ-019 WAIT: req_ready=0; counter decrements each cycle; at counter=0 transition to RESP.
REQ-020 Memory access (write commit or read sample) SHALL occur on the edge entering RESP; response fields registered on that same edge.
REQ-021 Handshake at edge T -> rsp_valid high from cycle T+1+LATENCY.
REQ-022 RESP: rsp_valid=1, req_ready=0; rsp_rdata/rsp_err held stable until rsp_valid & rsp_ready at an edge, then -> IDLE.
REQ-023 No request accepted in the edge that completes a response; back-to-back throughput = one access per LATENCY+2 cycles minimum.
REQ-024 Store legality: req_be in {0001,0010,0100,1000,0011,1100,1111}; otherwise rsp_err=1, no byte written.
REQ-025 Legal store writes only enabled lanes; other bytes of word unchanged; rsp_rdata=0, rsp_err=0.
REQ-026 Loads ignore req_be and req_addr[1:0]; return full word; rsp_err=0; lane extraction and sign extension belong to initiator.
REQ-027 Load following a store to same word SHALL return post-store data.
REQ-028 Inputs other than req_valid ignored outside IDLE; req_valid held high while busy is not lost, accepted on return to IDLE.

Reset
REQ-029 rst_n low SHALL force, asynchronously: state IDLE, counter 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, req_ready 0 while rst_n low.
REQ-030 req_ready SHALL rise in first cycle after rst_n deasserts.
REQ-031 Reset during WAIT SHALL abort the access; a pending store SHALL NOT modify memory.
REQ-032 Reset during RESP SHALL drop the response; an already-committed store remains.
REQ-033 Memory array contents SHALL NOT be reset; unwritten words read undefined.

Verification
REQ-034 LATENCY=2: store addr 0x010 be 1111 wdata 0xDEADBEEF accepted at T -> rsp_valid at T+3, rsp_err 0; load 0x010 -> rsp_rdata 0xDEADBEEF.
REQ-035 Store addr 0x011 be 0010 wdata 0x55555555 over 0xDEADBEEF, then load 0x010 -> 0xDEAD55EF.
REQ-036 Store be 0101 to word holding 0x12345678 -> rsp_err 1, rsp_rdata 0; reload -> 0x12345678.
REQ-037 Hold rsp_ready low 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready 0 throughout; release -> IDLE next cycle.
REQ-038 Store 0xCAFEF00D to word holding 0x00000000, assert rst_n low during WAIT -> all outputs 0 immediately; reload returns 0x00000000.
REQ-039 LATENCY=0: load accepted at T -> rsp_valid at T+1; with rsp_ready tied 1 and req_valid held, new accept every 2 cycles.
